aes_dec_cu: RTL and testbench



---
 rtl/aes_dec_pkg.sv | 25 ++
 rtl/aes_dec_round_ctr.sv | 38 +++
 rtl/aes_dec_cu.sv | 130 +++++++++++++
 tb/tb_aes_dec_cu.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the AES inverse-cipher control unit.
package aes_dec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_INIT   = 3'd2,
    ST_ROUND  = 3'd3,
    ST_FINAL  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Round count for a given AES key length in bits; unknown sizes fall back to AES-128.
  function automatic int nr_for_key(input int key_bits);
    case (key_bits)
      192:     return 12;
      256:     return 14;
      default: return 10;
    endcase
  endfunction

  localparam int NR_DEFAULT = nr_for_key(128);
  localparam int AW_DEFAULT = 4;

endpackage

// File: rtl/aes_dec_round_ctr.sv
// Loadable AW-bit up/down round counter with terminal-count flags.
module aes_dec_round_ctr #(
  parameter int AW = 4,
  parameter int NR = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          en,
  input  logic          up,
  output logic [AW-1:0] count,
  output logic          at_nr,
  output logic          at_one
);

  logic [AW-1:0] count_reg;

  // Saturating at both ends so the count can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en) begin
      if (up && (count_reg != '1)) begin
        count_reg <= count_reg + 1'b1;
      end else if (!up && (count_reg != '0)) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  assign count  = count_reg;
  assign at_nr  = (count_reg == AW'(NR));
  assign at_one = (count_reg == AW'(1));

endmodule

// File: rtl/aes_dec_cu.sv
// Moore control unit for the AES inverse cipher: key expansion, then rounds NR..0.
// Optional key reuse (skip KEYEXP when keys are already stored) under AES_DEC_KEY_CACHE_EN.
module aes_dec_cu
  import aes_dec_pkg::*;
#(
  parameter int NR = NR_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
`ifdef AES_DEC_KEY_CACHE_EN
  input  logic          new_key,
`endif
  output logic          busy,
  output logic          genk,
  output logic          key_we,
  output logic [AW-1:0] rk_addr,
  output logic          ld_state,
  output logic          dec,
  output logic          mix_en,
  output logic          done
);

  state_t        state_reg, state_next;
  logic          ctr_load;
  logic [AW-1:0] ctr_load_val;
  logic          ctr_en;
  logic          ctr_up;
  logic [AW-1:0] count;
  logic          at_nr;
  logic          at_one;
  logic          skip_kexp;

  aes_dec_round_ctr #(.AW(AW), .NR(NR)) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (ctr_load_val),
    .en       (ctr_en),
    .up       (ctr_up),
    .count    (count),
    .at_nr    (at_nr),
    .at_one   (at_one)
  );

`ifdef AES_DEC_KEY_CACHE_EN
  logic keys_valid_reg;

  // Keys become reusable only once a full expansion has completed.
  always_ff @(posedge clk) begin
    if (rst) begin
      keys_valid_reg <= 1'b0;
    end else if ((state_reg == ST_KEYEXP) && at_nr) begin
      keys_valid_reg <= 1'b1;
    end
  end

  assign skip_kexp = keys_valid_reg && !new_key;
`else
  assign skip_kexp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ctr_load     = 1'b0;
    ctr_load_val = '0;
    ctr_en       = 1'b0;
    ctr_up       = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          ctr_load = 1'b1;
          if (skip_kexp) begin
            state_next   = ST_INIT;
            ctr_load_val = AW'(NR);
          end else begin
            state_next   = ST_KEYEXP;
            ctr_load_val = AW'(1);
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_KEYEXP: begin
        if (at_nr) begin
          state_next = ST_INIT;
        end else begin
          ctr_en = 1'b1;
          ctr_up = 1'b1;
        end
      end
      ST_INIT: begin
        state_next = ST_ROUND;
        ctr_en     = 1'b1;
      end
      ST_ROUND: begin
        // Decrementing out of 1 leaves the counter at 0 for the final round.
        ctr_en = 1'b1;
        if (at_one) begin
          state_next = ST_FINAL;
        end
      end
      ST_FINAL: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign genk     = (state_reg == ST_KEYEXP);
  assign key_we   = (state_reg == ST_KEYEXP);
  assign ld_state = (state_reg == ST_INIT);
  assign dec      = (state_reg == ST_ROUND) || (state_reg == ST_FINAL);
  assign mix_en   = (state_reg == ST_ROUND);
  assign done     = (state_reg == ST_DONE);
  assign rk_addr  = busy ? count : '0;

endmodule

// File: tb/tb_aes_dec_cu.sv
// Scoreboard bench for aes_dec_cu: per-cycle expected output vectors queued at launch time.
module tb_aes_dec_cu;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic start10 = 1'b0;
  logic start14 = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
  logic new_key = 1'b1;
`endif

  logic       busy10, genk10, kwe10, ld10, dec10, mix10, done10;
  logic [3:0] addr10;
  logic       busy14, genk14, kwe14, ld14, dec14, mix14, done14;
  logic [3:0] addr14;

  always #5 clk = ~clk;

  aes_dec_cu #(.NR(10), .AW(4)) dut10 (
    .clk      (clk),
    .rst      (rst),
    .start    (start10),
`ifdef AES_DEC_KEY_CACHE_EN
    .new_key  (new_key),
`endif
    .busy     (busy10),
    .genk     (genk10),
    .key_we   (kwe10),
    .rk_addr  (addr10),
    .ld_state (ld10),
    .dec      (dec10),
    .mix_en   (mix10),
    .done     (done10)
  );

  aes_dec_cu #(.NR(14), .AW(4)) dut14 (
    .clk      (clk),
    .rst      (rst),
    .start    (start14),
`ifdef AES_DEC_KEY_CACHE_EN
    .new_key  (new_key),
`endif
    .busy     (busy14),
    .genk     (genk14),
    .key_we   (kwe14),
    .rk_addr  (addr14),
    .ld_state (ld14),
    .dec      (dec14),
    .mix_en   (mix14),
    .done     (done14)
  );

  typedef struct {
    int         cyc;
    logic [10:0] vec;
  } exp_t;

  exp_t q10[$];
  exp_t q14[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   last_base = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Vector layout: {busy, genk, key_we, rk_addr[3:0], ld_state, dec, mix_en, done}
  function automatic logic [10:0] exp_vec(input int nr, input int k);
    logic [10:0] v;
    v = '0;
    if (k < nr)              v = {3'b111, 4'(k + 1), 4'b0000};
    else if (k == nr)        v = {3'b100, 4'(nr), 4'b1000};
    else if (k < 2 * nr)     v = {3'b100, 4'(2 * nr - k), 4'b0110};
    else if (k == 2 * nr)    v = {3'b100, 4'd0, 4'b0100};
    else if (k == 2 * nr + 1) v = {3'b000, 4'd0, 4'b0001};
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle=%0d got=%b expected=%b", nm, cyc, act, exp);
  endtask

  logic [10:0] e10, e14;
  always @(negedge clk) begin
    if (cyc > 0) begin
      e10 = '0;
      e14 = '0;
      if (q10.size() > 0 && q10[0].cyc == cyc) e10 = q10.pop_front().vec;
      if (q14.size() > 0 && q14[0].cyc == cyc) e14 = q14.pop_front().vec;
      cmp("dut10_outputs", {busy10, genk10, kwe10, addr10, ld10, dec10, mix10, done10}, e10);
      cmp("dut14_outputs", {busy14, genk14, kwe14, addr14, ld14, dec14, mix14, done14}, e14);
      if (done10) $display("dut10 done at cycle %0d", cyc);
      if (done14) $display("dut14 done at cycle %0d", cyc);
    end
  end

  task automatic push(input int which, input int nr, input int base, input int k1, input int koff);
    exp_t e;
    for (int k = 0; k <= k1; k++) begin
      e.cyc = base + k;
      e.vec = exp_vec(nr, k + koff);
      if (which == 0) q10.push_back(e);
      else q14.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int abs_cyc);
    while (cyc < abs_cyc) step();
  endtask

  // Drives a one-cycle start; op cycle 0 is the cycle after the sampling edge.
  task automatic launch(input int which, input int nr, input int k1, input int koff);
    int base;
    base = cyc + 1;
    push(which, nr, base, k1, koff);
    if (which == 0) start10 = 1'b1;
    else start14 = 1'b1;
    step();
    start10 = 1'b0;
    start14 = 1'b0;
    last_base = base;
  endtask

  initial begin
    int b;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single start, NR=10
    launch(0, 10, 21, 0);
    wait_until(last_base + 24);

    // Start pulses in op cycles 3 and 15 must be ignored
    launch(0, 10, 21, 0);
    b = last_base;
    wait_until(b + 3);
    start10 = 1'b1;
    step();
    start10 = 1'b0;
    wait_until(b + 15);
    start10 = 1'b1;
    step();
    start10 = 1'b0;
    wait_until(b + 24);

    // Start held high: back-to-back operations every 22 cycles
    b = cyc + 1;
    for (int i = 0; i < 3; i++) push(0, 10, b + 22 * i, 21, 0);
    start10 = 1'b1;
    wait_until(b + 49);
    start10 = 1'b0;
    wait_until(b + 70);

    // Reset during ROUND (cycle 13), then a fresh full operation
    launch(0, 10, 13, 0);
    b = last_base;
    wait_until(b + 13);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_until(b + 18);
    launch(0, 10, 21, 0);
    wait_until(last_base + 24);

    // NR=14 instance
    launch(1, 14, 29, 0);
    wait_until(last_base + 32);

`ifdef AES_DEC_KEY_CACHE_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    new_key = 1'b0;
    launch(0, 10, 21, 0);
    wait_until(last_base + 24);
    launch(0, 10, 11, 10);
    wait_until(last_base + 14);
    new_key = 1'b1;
    launch(0, 10, 21, 0);
    wait_until(last_base + 24);
`endif

    repeat (3) step();
    cmp("q10_drained", 11'(q10.size()), 11'd0);
    cmp("q14_drained", 11'(q14.size()), 11'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
